oclib_axim_arbiter: RTL and testbench

Shares one downstream AXI4 manager port between `NumRequesters` upstream AXI4 managers. It sits in front of a shared memory or CSR target, typically upstream of an AXI FIFO stage. AR and AW are arbitrated independently with round-robin. The requester index is encoded into the top ID bits so that R and B responses route back by ID. W beats are ordered by AW grant order.

---
 rtl/oclib_pkg.sv | 58 +++++
 rtl/oclib_arbiter_rr.sv | 48 ++++
 rtl/oclib_fifo.sv | 48 ++++
 rtl/oclib_axim_arbiter.sv | 121 ++++++++++++
 tb/tb_oclib_axim_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oclib_pkg.sv
// rtl/oclib_pkg.sv - shared AXI4 manager request/feedback types and fabric helpers
package oclib_pkg;

  localparam int AxiIdWidth = 16;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [63:0]           addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi4_a_s;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
  } axi4_w_256_s;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [255:0]          data;
    logic [1:0]            resp;
    logic                  last;
  } axi4_r_256_s;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } axi4_b_s;

  typedef struct packed {
    axi4_a_s     ar;
    logic        arvalid;
    axi4_a_s     aw;
    logic        awvalid;
    axi4_w_256_s w;
    logic        wvalid;
    logic        rready;
    logic        bready;
  } axi4m_256_s;

  typedef struct packed {
    logic        arready;
    logic        awready;
    logic        wready;
    axi4_r_256_s r;
    logic        rvalid;
    axi4_b_s     b;
    logic        bvalid;
  } axi4m_256_fb_s;

  // Number of ID bits needed to tag the source of a transaction among n managers.
  function automatic int src_bits(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

endpackage

// File: rtl/oclib_arbiter_rr.sv
// rtl/oclib_arbiter_rr.sv - round-robin arbiter, one-hot plus index grant
module oclib_arbiter_rr #(
  parameter int N    = 2,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clock_i,
  input  logic            reset_ni,
  input  logic [N-1:0]    req_i,
  input  logic            adv_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  // Winner is the requester with the smallest distance at or after the pointer.
  always_comb begin
    int off, best;
    off     = 0;
    best    = N;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      off = (i >= int'(ptr_q)) ? i - int'(ptr_q) : i + N - int'(ptr_q);
      if (req_i[i] && off < best) begin
        best    = off;
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) gnt_o[i] = valid_o && (idx_o == IdxW'(i));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && valid_o) ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) ptr_q <= '0;
    else           ptr_q <= ptr_d;
  end

endmodule

// File: rtl/oclib_fifo.sv
// rtl/oclib_fifo.sv - small register FIFO, first-word fall-through, push+pop when full
module oclib_fifo #(
  parameter int Width = 1,
  parameter int Depth = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [Width-1:0] dout_o,
  output logic             empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/oclib_axim_arbiter.sv
// rtl/oclib_axim_arbiter.sv - N:1 AXI4 manager arbiter, source index carried in top ID bits
module oclib_axim_arbiter
  import oclib_pkg::*;
#(
  parameter type AximType      = oclib_pkg::axi4m_256_s,
  parameter type AximFbType    = oclib_pkg::axi4m_256_fb_s,
  parameter int  NumRequesters = 2,
  parameter int  WOrderDepth   = 8
) (
  input  logic      clock_i,
  input  logic      reset_ni,
  input  AximType   in_i    [NumRequesters],
  output AximFbType in_fb_o [NumRequesters],
  output AximType   out_o,
  input  AximFbType out_fb_i
);

  localparam int SrcBits = src_bits(NumRequesters);
  localparam int IdxW    = (SrcBits > 0) ? SrcBits : 1;
  localparam int IdW     = $bits(out_o.ar.id);
  localparam logic [IdW-1:0] TopMask = ~({IdW{1'b1}} >> SrcBits);

  logic [NumRequesters-1:0] ar_req, aw_req, ar_gnt, aw_gnt;
  logic [IdxW-1:0]          ar_idx, aw_idx, w_head, r_src, b_src;
  logic                     ar_any, aw_any, ar_go, aw_go;
  logic                     fifo_rst, fifo_full, fifo_empty, w_pop;
  AximType                  req_q, req_d;

  always_comb begin
    for (int i = 0; i < NumRequesters; i++) begin
      ar_req[i] = in_i[i].arvalid;
      aw_req[i] = in_i[i].awvalid;
    end
  end

  oclib_arbiter_rr #(.N(NumRequesters), .IdxW(IdxW)) u_ar_rr (
    .clock_i (clock_i), .reset_ni(reset_ni), .req_i(ar_req), .adv_i(ar_go),
    .gnt_o   (ar_gnt),  .idx_o   (ar_idx),   .valid_o(ar_any)
  );

  oclib_arbiter_rr #(.N(NumRequesters), .IdxW(IdxW)) u_aw_rr (
    .clock_i (clock_i), .reset_ni(reset_ni), .req_i(aw_req), .adv_i(aw_go),
    .gnt_o   (aw_gnt),  .idx_o   (aw_idx),   .valid_o(aw_any)
  );

  assign ar_go = ar_any && (!req_q.arvalid || out_fb_i.arready);
  assign aw_go = aw_any && !fifo_full && (!req_q.awvalid || out_fb_i.awready);

  // Only the ar/aw halves of req_q are live; the rest stays at reset value.
  always_comb begin
    req_d = req_q;
    if (out_fb_i.arready) req_d.arvalid = 1'b0;
    if (out_fb_i.awready) req_d.awvalid = 1'b0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (ar_go && ar_gnt[i]) begin
        req_d.ar      = in_i[i].ar;
        req_d.ar.id   = (in_i[i].ar.id & ~TopMask) | (IdW'(ar_idx) << (IdW - SrcBits));
        req_d.arvalid = 1'b1;
      end
      if (aw_go && aw_gnt[i]) begin
        req_d.aw      = in_i[i].aw;
        req_d.aw.id   = (in_i[i].aw.id & ~TopMask) | (IdW'(aw_idx) << (IdW - SrcBits));
        req_d.awvalid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) req_q <= '0;
    else           req_q <= req_d;
  end

  assign fifo_rst = !reset_ni;

  oclib_fifo #(.Width(IdxW), .Depth(WOrderDepth)) u_worder (
    .clock_i(clock_i), .reset_i(fifo_rst),
    .push_i (aw_go),   .din_i  (aw_idx), .full_o (fifo_full),
    .pop_i  (w_pop),   .dout_o (w_head), .empty_o(fifo_empty)
  );

  assign r_src = IdxW'(out_fb_i.r.id >> (IdW - SrcBits));
  assign b_src = IdxW'(out_fb_i.b.id >> (IdW - SrcBits));

  always_comb begin
    out_o        = req_q;
    out_o.wvalid = 1'b0;
    out_o.rready = 1'b0;
    out_o.bready = 1'b0;
    for (int i = 0; i < NumRequesters; i++) begin
      in_fb_o[i]         = '0;
      in_fb_o[i].arready = ar_go && ar_gnt[i];
      in_fb_o[i].awready = aw_go && aw_gnt[i];
      in_fb_o[i].r       = out_fb_i.r;
      in_fb_o[i].r.id    = out_fb_i.r.id & ~TopMask;
      in_fb_o[i].b       = out_fb_i.b;
      in_fb_o[i].b.id    = out_fb_i.b.id & ~TopMask;
      if (!fifo_empty && w_head == IdxW'(i)) begin
        out_o.w            = in_i[i].w;
        out_o.wvalid       = in_i[i].wvalid;
        in_fb_o[i].wready  = out_fb_i.wready;
      end
      if (r_src == IdxW'(i)) begin
        in_fb_o[i].rvalid = out_fb_i.rvalid;
        out_o.rready      = in_i[i].rready;
      end
      if (b_src == IdxW'(i)) begin
        in_fb_o[i].bvalid = out_fb_i.bvalid;
        out_o.bready      = in_i[i].bready;
      end
    end
    w_pop = out_o.wvalid && out_fb_i.wready && out_o.w.last;
  end

  for (genvar i = 0; i < NumRequesters; i++) begin : g_id_chk
    a_arid_top_zero : assert property (@(posedge clock_i) disable iff (!reset_ni)
      in_i[i].arvalid |-> ((in_i[i].ar.id & TopMask) == '0));
    a_awid_top_zero : assert property (@(posedge clock_i) disable iff (!reset_ni)
      in_i[i].awvalid |-> ((in_i[i].aw.id & TopMask) == '0));
  end

endmodule

// File: tb/tb_oclib_axim_arbiter.sv
// tb/tb_oclib_axim_arbiter.sv - directed self-checking bench for oclib_axim_arbiter
module tb_oclib_axim_arbiter;
  import oclib_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  axi4m_256_s    in_s  [2];
  axi4m_256_fb_s in_fb [2];
  axi4m_256_s    out_s;
  axi4m_256_fb_s out_fb;
  int            vec  = 0;
  int            miss = 0;

  always #5 clk = ~clk;

  oclib_axim_arbiter #(.NumRequesters(2), .WOrderDepth(2)) dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .in_i    (in_s),
    .in_fb_o (in_fb),
    .out_o   (out_s),
    .out_fb_i(out_fb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] rdy;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_s[i] = '0;
      in_s[i].wvalid = 1'b1;
      in_s[i].w.last = 1'b1;
    end
    out_fb = '0;
    out_fb.wready = 1'b1;
    step();
    step();
    vec++;
    if ({out_s.arvalid, out_s.awvalid, out_s.wvalid} !== 3'b000) begin
      miss++;
      $display("FAIL reset_out_valids got=%b exp=000", {out_s.arvalid, out_s.awvalid, out_s.wvalid});
    end
    rdy = {in_fb[1].arready, in_fb[1].awready, in_fb[1].wready,
           in_fb[0].arready, in_fb[0].awready, in_fb[0].wready};
    vec++;
    if (rdy !== 6'b0) begin
      miss++;
      $display("FAIL reset_in_readies got=%b exp=000000", rdy);
    end
    in_s[0].wvalid = 1'b0;
    in_s[1].wvalid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_rr_arbitration();
    logic [1:0]  exp_rdy;
    logic [15:0] exp_id;
    in_s[0].ar.id = 16'h0010; in_s[0].ar.addr = 64'hA000; in_s[0].arvalid = 1'b1;
    in_s[1].ar.id = 16'h0021; in_s[1].ar.addr = 64'hB000; in_s[1].arvalid = 1'b1;
    out_fb.arready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_id  = (k % 2 == 1) ? 16'h8021 : 16'h0010;
      vec++;
      if ({in_fb[1].arready, in_fb[0].arready} !== exp_rdy) begin
        miss++;
        $display("FAIL rr_arready beat=%0d got=%b exp=%b", k, {in_fb[1].arready, in_fb[0].arready}, exp_rdy);
      end
      step();
      vec++;
      if (out_s.arvalid !== 1'b1 || out_s.ar.id !== exp_id) begin
        miss++;
        $display("FAIL rr_out_arid beat=%0d got=%b/%h exp=1/%h", k, out_s.arvalid, out_s.ar.id, exp_id);
      end
    end
    in_s[0].arvalid = 1'b0;
    in_s[1].arvalid = 1'b0;
    step();
    vec++;
    if (out_s.arvalid !== 1'b0) begin
      miss++;
      $display("FAIL rr_drain got=%b exp=0", out_s.arvalid);
    end
  endtask

  task automatic test_backpressure();
    in_s[0].ar.id = 16'h0005; in_s[0].ar.addr = 64'h1000; in_s[0].arvalid = 1'b1;
    out_fb.arready = 1'b0;
    #1;
    vec++;
    if (in_fb[0].arready !== 1'b1) begin
      miss++;
      $display("FAIL bp_first_arready got=%b exp=1", in_fb[0].arready);
    end
    step();
    in_s[0].ar.addr = 64'h2000;
    for (int c = 0; c < 5; c++) begin
      #1;
      vec++;
      if (out_s.arvalid !== 1'b1 || out_s.ar.addr !== 64'h1000 || out_s.ar.id !== 16'h0005 ||
          in_fb[0].arready !== 1'b0) begin
        miss++;
        $display("FAIL bp_stall cyc=%0d got=%b/%h/%h/%b exp=1/1000/0005/0", c,
                 out_s.arvalid, out_s.ar.addr, out_s.ar.id, in_fb[0].arready);
      end
      step();
    end
    out_fb.arready = 1'b1;
    #1;
    vec++;
    if (in_fb[0].arready !== 1'b1) begin
      miss++;
      $display("FAIL bp_release_arready got=%b exp=1", in_fb[0].arready);
    end
    step();
    vec++;
    if (out_s.arvalid !== 1'b1 || out_s.ar.addr !== 64'h2000) begin
      miss++;
      $display("FAIL bp_second_ar got=%b/%h exp=1/2000", out_s.arvalid, out_s.ar.addr);
    end
    in_s[0].arvalid = 1'b0;
    step();
  endtask

  task automatic test_r_b_routing();
    out_fb.r.id = 16'h8003; out_fb.r.data = 256'hABCD; out_fb.rvalid = 1'b1;
    in_s[1].rready = 1'b1; in_s[0].rready = 1'b0;
    #1;
    vec++;
    if ({in_fb[1].rvalid, in_fb[0].rvalid, out_s.rready} !== 3'b101 || in_fb[1].r.id !== 16'h0003) begin
      miss++;
      $display("FAIL r_route_1 got=%b/%h exp=101/0003",
               {in_fb[1].rvalid, in_fb[0].rvalid, out_s.rready}, in_fb[1].r.id);
    end
    out_fb.r.id = 16'h0004;
    #1;
    vec++;
    if ({in_fb[1].rvalid, in_fb[0].rvalid, out_s.rready} !== 3'b010 || in_fb[0].r.id !== 16'h0004) begin
      miss++;
      $display("FAIL r_route_0 got=%b/%h exp=010/0004",
               {in_fb[1].rvalid, in_fb[0].rvalid, out_s.rready}, in_fb[0].r.id);
    end
    out_fb.rvalid = 1'b0;
    out_fb.b.id = 16'h8003; out_fb.bvalid = 1'b1;
    in_s[1].bready = 1'b1; in_s[0].bready = 1'b0;
    #1;
    vec++;
    if ({in_fb[1].bvalid, in_fb[0].bvalid, out_s.bready} !== 3'b101 || in_fb[1].b.id !== 16'h0003) begin
      miss++;
      $display("FAIL b_route_1 got=%b/%h exp=101/0003",
               {in_fb[1].bvalid, in_fb[0].bvalid, out_s.bready}, in_fb[1].b.id);
    end
    out_fb.bvalid = 1'b0;
    in_s[1].rready = 1'b0;
    in_s[1].bready = 1'b0;
    step();
  endtask

  task automatic test_w_order();
    int          exp_src  [6] = '{1, 1, 1, 1, 0, 0};
    int          exp_beat [6] = '{0, 1, 2, 3, 0, 1};
    logic        exp_last [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          b0 = 0;
    int          b1 = 0;
    logic [255:0] exp_data;
    out_fb.awready = 1'b1;
    out_fb.wready  = 1'b1;
    in_s[1].aw.id = 16'h0011; in_s[1].aw.len = 8'd3; in_s[1].awvalid = 1'b1;
    #1;
    vec++;
    if ({in_fb[1].awready, in_fb[0].awready} !== 2'b10) begin
      miss++;
      $display("FAIL wo_aw1_ready got=%b exp=10", {in_fb[1].awready, in_fb[0].awready});
    end
    step();
    in_s[1].awvalid = 1'b0;
    in_s[0].aw.id = 16'h0022; in_s[0].aw.len = 8'd1; in_s[0].awvalid = 1'b1;
    #1;
    vec++;
    if (out_s.awvalid !== 1'b1 || out_s.aw.id !== 16'h8011 || in_fb[0].awready !== 1'b1) begin
      miss++;
      $display("FAIL wo_aw1_out got=%b/%h/%b exp=1/8011/1", out_s.awvalid, out_s.aw.id, in_fb[0].awready);
    end
    step();
    in_s[0].awvalid = 1'b0;
    #1;
    vec++;
    if (out_s.aw.id !== 16'h0022) begin
      miss++;
      $display("FAIL wo_aw0_out got=%h exp=0022", out_s.aw.id);
    end
    in_s[0].wvalid = 1'b1;
    in_s[1].wvalid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      in_s[0].w.data = 256'(b0);
      in_s[0].w.last = (b0 == 1);
      in_s[1].w.data = 256'(32'h100 + b1);
      in_s[1].w.last = (b1 == 3);
      #1;
      exp_data = (exp_src[n] == 1) ? 256'(32'h100 + exp_beat[n]) : 256'(exp_beat[n]);
      vec++;
      if (out_s.wvalid !== 1'b1 || out_s.w.data !== exp_data || out_s.w.last !== exp_last[n] ||
          in_fb[0].wready !== (exp_src[n] == 0) || in_fb[1].wready !== (exp_src[n] == 1)) begin
        miss++;
        $display("FAIL wo_beat n=%0d got=%b/%h/%b/%b%b exp=1/%h/%b/%b%b", n, out_s.wvalid,
                 out_s.w.data[15:0], out_s.w.last, in_fb[1].wready, in_fb[0].wready,
                 exp_data[15:0], exp_last[n], exp_src[n] == 1, exp_src[n] == 0);
      end
      step();
      if (exp_src[n] == 1) b1++;
      else b0++;
    end
    in_s[1].wvalid = 1'b0;
    #1;
    vec++;
    if (out_s.wvalid !== 1'b0 || in_fb[0].wready !== 1'b0) begin
      miss++;
      $display("FAIL wo_empty got=%b/%b exp=0/0", out_s.wvalid, in_fb[0].wready);
    end
    in_s[0].wvalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    in_s[0].aw.id = 16'h0033; in_s[0].aw.len = 8'd0; in_s[0].awvalid = 1'b1;
    in_s[0].w.data = 256'h33; in_s[0].w.last = 1'b1;
    out_fb.awready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      vec++;
      if (in_fb[0].awready !== 1'b1) begin
        miss++;
        $display("FAIL ff_fill aw=%0d got=%b exp=1", c, in_fb[0].awready);
      end
      step();
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      vec++;
      if (in_fb[0].awready !== 1'b0 || out_s.wvalid !== 1'b0) begin
        miss++;
        $display("FAIL ff_blocked cyc=%0d got=%b/%b exp=0/0", c, in_fb[0].awready, out_s.wvalid);
      end
      step();
    end
    in_s[0].wvalid = 1'b1;
    #1;
    vec++;
    if (out_s.wvalid !== 1'b1 || in_fb[0].wready !== 1'b1 || in_fb[0].awready !== 1'b0) begin
      miss++;
      $display("FAIL ff_wlast got=%b/%b/%b exp=1/1/0", out_s.wvalid, in_fb[0].wready, in_fb[0].awready);
    end
    step();
    in_s[0].wvalid = 1'b0;
    #1;
    vec++;
    if (in_fb[0].awready !== 1'b1) begin
      miss++;
      $display("FAIL ff_unblock got=%b exp=1", in_fb[0].awready);
    end
    step();
    in_s[0].awvalid = 1'b0;
    in_s[0].wvalid  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      vec++;
      if (out_s.wvalid !== 1'b1) begin
        miss++;
        $display("FAIL ff_drain beat=%0d got=%b exp=1", c, out_s.wvalid);
      end
      step();
    end
    #1;
    vec++;
    if (out_s.wvalid !== 1'b0) begin
      miss++;
      $display("FAIL ff_drained got=%b exp=0", out_s.wvalid);
    end
    in_s[0].wvalid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    in_s[1].aw.id = 16'h0044; in_s[1].aw.len = 8'd3; in_s[1].awvalid = 1'b1;
    #1;
    step();
    in_s[1].awvalid = 1'b0;
    in_s[1].wvalid = 1'b1; in_s[1].w.last = 1'b0;
    out_fb.wready = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      vec++;
      if ({out_s.arvalid, out_s.awvalid, out_s.wvalid, in_fb[1].wready, in_fb[0].wready} !== 5'b0) begin
        miss++;
        $display("FAIL rst_mid cyc=%0d got=%b exp=00000", c,
                 {out_s.arvalid, out_s.awvalid, out_s.wvalid, in_fb[1].wready, in_fb[0].wready});
      end
      step();
    end
    rst_n = 1'b1;
    in_s[1].wvalid = 1'b0;
    step();
    in_s[0].aw.id = 16'h0055; in_s[0].aw.len = 8'd0; in_s[0].awvalid = 1'b1;
    in_s[1].awvalid = 1'b1;
    #1;
    vec++;
    if ({in_fb[1].awready, in_fb[0].awready} !== 2'b01) begin
      miss++;
      $display("FAIL rst_ptr_grant got=%b exp=01", {in_fb[1].awready, in_fb[0].awready});
    end
    step();
    in_s[0].awvalid = 1'b0;
    in_s[1].awvalid = 1'b0;
    in_s[0].wvalid = 1'b1; in_s[0].w.last = 1'b1; in_s[0].w.data = 256'h55;
    #1;
    vec++;
    if (out_s.awvalid !== 1'b1 || out_s.aw.id !== 16'h0055 || out_s.wvalid !== 1'b1 ||
        out_s.w.data !== 256'h55 || in_fb[0].wready !== 1'b1) begin
      miss++;
      $display("FAIL rst_new_burst got=%b/%h/%b/%h/%b exp=1/0055/1/55/1", out_s.awvalid,
               out_s.aw.id, out_s.wvalid, out_s.w.data[15:0], in_fb[0].wready);
    end
    step();
    in_s[0].wvalid = 1'b0;
    #1;
    vec++;
    if (out_s.wvalid !== 1'b0) begin
      miss++;
      $display("FAIL rst_new_done got=%b exp=0", out_s.wvalid);
    end
  endtask

  initial begin
    test_reset();
    test_rr_arbitration();
    test_backpressure();
    test_r_b_routing();
    test_w_order();
    test_fifo_full();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
